// File: rtl/conv_job_ctrl_if.sv
// ============================================================================
//  Module   : conv_job_ctrl_if
//  Purpose  : Job handshake between conv_job_ctrl and the compute engine.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface conv_job_ctrl_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH
) ();
  logic                  job_valid;
  logic                  job_ready;
  logic [15:0]           job_co;
  logic [15:0]           job_oy;
  logic [15:0]           job_ox;
  logic signed [15:0]    job_iy;
  logic signed [15:0]    job_ix;
  logic [DATA_WIDTH-1:0] job_kern_addr;
  logic [DATA_WIDTH-1:0] job_out_addr;
  logic                  job_done;

  modport master (
    output job_valid, job_co, job_oy, job_ox, job_iy, job_ix,
           job_kern_addr, job_out_addr,
    input  job_ready, job_done
  );

  modport slave (
    input  job_valid, job_co, job_oy, job_ox, job_iy, job_ix,
           job_kern_addr, job_out_addr,
    output job_ready, job_done
  );
endinterface

`default_nettype wire

// File: rtl/conv_job_ctrl.sv
// ============================================================================
//  Module   : conv_job_ctrl
//  Purpose  : Latches a conv layer config, validates it and issues one job per
//             output pixel (co outer, oy, ox inner) with outstanding tracking.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module conv_job_ctrl #(
  parameter int DATA_WIDTH      = `DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  conv_mode,
  input  logic [7:0]            kernel_size,
  input  logic [7:0]            stride,
  input  logic [7:0]            padding,
  input  logic [DATA_WIDTH-1:0] kernel_baseaddr,
  input  logic [DATA_WIDTH-1:0] output_baseaddr,
  input  logic [DATA_WIDTH-1:0] feature_width,
  input  logic [DATA_WIDTH-1:0] feature_height,
  input  logic [DATA_WIDTH-1:0] feature_chin,
  input  logic [DATA_WIDTH-1:0] feature_chout,
  input  logic [DATA_WIDTH-1:0] output_width,
  input  logic [DATA_WIDTH-1:0] output_height,
  output logic                  running,
  output logic                  compute_done,
  output logic                  exception,
  conv_job_ctrl_if.master       job
);

  localparam int XW    = DATA_WIDTH + 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t                state_q;
  logic                  mode_q;
  logic [7:0]            ksz_q, str_q, pad_q;
  logic [DATA_WIDTH-1:0] kbase_q, obase_q;
  logic [DATA_WIDTH-1:0] fw_q, fh_q, chin_q, chout_q, ow_q, oh_q;
  logic [DATA_WIDTH-1:0] kstride_q;
  logic [CNT_W-1:0]      outst_q, outst_d;
  logic                  running_q, cdone_q, exc_q, valid_q;
  logic [15:0]           co_q, oy_q, ox_q, iy_q, ix_q;
  logic [DATA_WIDTH-1:0] kaddr_q, oaddr_q;

  logic                  launch, accept, spurious, in_run;
  logic                  ox_wrap, oy_wrap, last_job, cfg_bad;
  logic [XW-1:0]         pw, ph, w_lo, w_hi, h_lo, h_hi;
  logic [DATA_WIDTH-1:0] kstride_d;
  logic [15:0]           neg_pad;

  assign launch   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign in_run   = (state_q == S_CHECK || state_q == S_ISSUE || state_q == S_DRAIN);
  assign accept   = valid_q && job.job_ready;
  assign spurious = job.job_done && (outst_q == '0);

  // Geometry test in widened arithmetic; ow/oh==0 wraps here but is rejected separately
  assign pw   = XW'(fw_q) + (XW'(pad_q) << 1);
  assign ph   = XW'(fh_q) + (XW'(pad_q) << 1);
  assign w_lo = (XW'(ow_q) - XW'(1)) * XW'(str_q) + XW'(ksz_q);
  assign w_hi = XW'(ow_q) * XW'(str_q) + XW'(ksz_q);
  assign h_lo = (XW'(oh_q) - XW'(1)) * XW'(str_q) + XW'(ksz_q);
  assign h_hi = XW'(oh_q) * XW'(str_q) + XW'(ksz_q);

  assign cfg_bad = (ksz_q == 8'd0) || (str_q == 8'd0)
                || (fw_q == '0) || (fh_q == '0) || (chin_q == '0) || (chout_q == '0)
                || (ow_q == '0) || (oh_q == '0)
                || (XW'(ksz_q) > pw) || (XW'(ksz_q) > ph)
                || !((w_lo <= pw) && (pw < w_hi))
                || !((h_lo <= ph) && (ph < h_hi));

  assign kstride_d = mode_q ? DATA_WIDTH'(ksz_q) * DATA_WIDTH'(ksz_q)
                            : DATA_WIDTH'(ksz_q) * DATA_WIDTH'(ksz_q) * chin_q;
  assign neg_pad   = 16'd0 - {8'd0, pad_q};

  assign ox_wrap  = (DATA_WIDTH'(ox_q) == ow_q - DATA_WIDTH'(1));
  assign oy_wrap  = (DATA_WIDTH'(oy_q) == oh_q - DATA_WIDTH'(1));
  assign last_job = ox_wrap && oy_wrap && (DATA_WIDTH'(co_q) == chout_q - DATA_WIDTH'(1));

  always_comb begin
    outst_d = outst_q;
    if (accept && !job.job_done)
      outst_d = outst_q + CNT_W'(1);
    else if (!accept && job.job_done)
      outst_d = outst_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      ksz_q     <= '0;
      str_q     <= '0;
      pad_q     <= '0;
      kbase_q   <= '0;
      obase_q   <= '0;
      fw_q      <= '0;
      fh_q      <= '0;
      chin_q    <= '0;
      chout_q   <= '0;
      ow_q      <= '0;
      oh_q      <= '0;
      kstride_q <= '0;
      outst_q   <= '0;
      running_q <= 1'b0;
      cdone_q   <= 1'b0;
      exc_q     <= 1'b0;
      valid_q   <= 1'b0;
      co_q      <= '0;
      oy_q      <= '0;
      ox_q      <= '0;
      iy_q      <= '0;
      ix_q      <= '0;
      kaddr_q   <= '0;
      oaddr_q   <= '0;
    end else if (launch) begin
      mode_q    <= conv_mode;
      ksz_q     <= kernel_size;
      str_q     <= stride;
      pad_q     <= padding;
      kbase_q   <= kernel_baseaddr;
      obase_q   <= output_baseaddr;
      fw_q      <= feature_width;
      fh_q      <= feature_height;
      chin_q    <= feature_chin;
      chout_q   <= feature_chout;
      ow_q      <= output_width;
      oh_q      <= output_height;
      outst_q   <= '0;
      running_q <= 1'b1;
      cdone_q   <= 1'b0;
      exc_q     <= 1'b0;
      valid_q   <= 1'b0;
      state_q   <= S_CHECK;
    end else if (in_run && spurious) begin
      // A completion with nothing in flight means the engine lost sync; stop issuing
      running_q <= 1'b0;
      exc_q     <= 1'b1;
      valid_q   <= 1'b0;
      state_q   <= S_ERR;
    end else begin
      case (state_q)
        S_CHECK: begin
          if (cfg_bad) begin
            running_q <= 1'b0;
            exc_q     <= 1'b1;
            state_q   <= S_ERR;
          end else begin
            kstride_q <= kstride_d;
            co_q      <= '0;
            oy_q      <= '0;
            ox_q      <= '0;
            iy_q      <= neg_pad;
            ix_q      <= neg_pad;
            kaddr_q   <= kbase_q;
            oaddr_q   <= obase_q;
            valid_q   <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          outst_q <= outst_d;
          if (accept) begin
            oaddr_q <= oaddr_q + DATA_WIDTH'(1);
            if (last_job) begin
              valid_q <= 1'b0;
              state_q <= S_DRAIN;
            end else begin
              valid_q <= (outst_d < MAX_CNT);
              if (!ox_wrap) begin
                ox_q <= ox_q + 16'd1;
                ix_q <= ix_q + {8'd0, str_q};
              end else begin
                ox_q <= '0;
                ix_q <= neg_pad;
                if (!oy_wrap) begin
                  oy_q <= oy_q + 16'd1;
                  iy_q <= iy_q + {8'd0, str_q};
                end else begin
                  oy_q    <= '0;
                  iy_q    <= neg_pad;
                  co_q    <= co_q + 16'd1;
                  kaddr_q <= kaddr_q + kstride_q;
                end
              end
            end
          end else begin
            valid_q <= (outst_d < MAX_CNT);
          end
        end
        S_DRAIN: begin
          outst_q <= outst_d;
          if (outst_q == '0) begin
            running_q <= 1'b0;
            cdone_q   <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign running           = running_q;
  assign compute_done      = cdone_q;
  assign exception         = exc_q;
  assign job.job_valid     = valid_q;
  assign job.job_co        = co_q;
  assign job.job_oy        = oy_q;
  assign job.job_ox        = ox_q;
  assign job.job_iy        = iy_q;
  assign job.job_ix        = ix_q;
  assign job.job_kern_addr = kaddr_q;
  assign job.job_out_addr  = oaddr_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_job_ctrl.sv
// ============================================================================
//  Module   : tb_conv_job_ctrl
//  Purpose  : Scoreboard bench for conv_job_ctrl with a simple engine model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv_job_ctrl;
  localparam int DW = 32;

  typedef struct packed {
    logic [15:0] co, oy, ox, iy, ix;
    logic [31:0] kaddr, oaddr;
  } job_t;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, conv_mode = 1'b0;
  logic [7:0]    kernel_size = '0, stride = '0, padding = '0;
  logic [DW-1:0] kernel_baseaddr = '0, output_baseaddr = '0;
  logic [DW-1:0] feature_width = '0, feature_height = '0, feature_chin = '0;
  logic [DW-1:0] feature_chout = '0, output_width = '0, output_height = '0;
  logic          running, compute_done, exception;

  conv_job_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  conv_job_ctrl #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .conv_mode(conv_mode),
    .kernel_size(kernel_size), .stride(stride), .padding(padding),
    .kernel_baseaddr(kernel_baseaddr), .output_baseaddr(output_baseaddr),
    .feature_width(feature_width), .feature_height(feature_height),
    .feature_chin(feature_chin), .feature_chout(feature_chout),
    .output_width(output_width), .output_height(output_height),
    .running(running), .compute_done(compute_done), .exception(exception),
    .job(bus)
  );

  always #5 clk = ~clk;

  int   errors = 0, checks = 0;
  int   cyc = 0, run_acc = 0, stall_left = 0;
  bit   ready_en = 1'b1, hold_done = 1'b0, force_done = 1'b0;
  int   due_q[$];
  job_t exp_q[$];
  job_t job9;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: drives ready/done on the falling edge, scores accepted jobs
  always @(negedge clk) begin
    job_t g, e;
    bus.job_done = 1'b0;
    if (force_done) begin
      bus.job_done = 1'b1;
      force_done   = 1'b0;
    end else if (!hold_done && due_q.size() > 0 && due_q[0] <= cyc) begin
      bus.job_done = 1'b1;
      void'(due_q.pop_front());
    end
    bus.job_ready = ready_en && (stall_left == 0);
    if (stall_left > 0) stall_left--;
    #1;
    if (bus.job_valid && bus.job_ready) begin
      g = {bus.job_co, bus.job_oy, bus.job_ox, bus.job_iy, bus.job_ix,
           bus.job_kern_addr, bus.job_out_addr};
      if (run_acc == 9) job9 = g;
      run_acc++;
      if (exp_q.size() == 0) begin
        check("unexpected_job", g, 0);
      end else begin
        e = exp_q.pop_front();
        check("job", g, e);
      end
      due_q.push_back(cyc + 2);
    end
  end

  task automatic set_cfg(input bit m, input int k, input int s, input int p,
                         input int fw, input int fh, input int chin, input int chout,
                         input int ow, input int oh, input int kb, input int ob);
    conv_mode = m;  kernel_size = 8'(k);  stride = 8'(s);  padding = 8'(p);
    feature_width = DW'(fw);  feature_height = DW'(fh);
    feature_chin = DW'(chin);  feature_chout = DW'(chout);
    output_width = DW'(ow);  output_height = DW'(oh);
    kernel_baseaddr = DW'(kb);  output_baseaddr = DW'(ob);
  endtask

  // Reference walk of the output tensor computed with direct multiplications
  task automatic push_layer();
    int ks, idx;
    job_t e;
    ks  = conv_mode ? int'(kernel_size) * int'(kernel_size)
                    : int'(kernel_size) * int'(kernel_size) * int'(feature_chin);
    idx = 0;
    for (int co = 0; co < int'(feature_chout); co++)
      for (int oy = 0; oy < int'(output_height); oy++)
        for (int ox = 0; ox < int'(output_width); ox++) begin
          e.co = 16'(co);  e.oy = 16'(oy);  e.ox = 16'(ox);
          e.iy = 16'(oy * int'(stride) - int'(padding));
          e.ix = 16'(ox * int'(stride) - int'(padding));
          e.kaddr = kernel_baseaddr + 32'(co * ks);
          e.oaddr = output_baseaddr + 32'(idx);
          exp_q.push_back(e);
          idx++;
        end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    run_acc = 0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int n_jobs);
    bit seen, prev;
    seen = 1'b0;
    prev = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk); #2;
      if (compute_done) begin
        seen = 1'b1;
        check({tag, "_run_fall"}, {prev, running}, 2'b10);
      end
      prev = running;
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
    check({tag, "_jobs"}, run_acc, n_jobs);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    check({tag, "_exc"}, exception, 0);
  endtask

  initial begin
    int   rcnt;
    bit   hit;
    logic [160:0] snap;

    #12;
    check("rst_status", {running, compute_done, exception}, 3'b000);
    check("rst_valid", bus.job_valid, 0);
    check("rst_fields", {bus.job_co, bus.job_oy, bus.job_ox, bus.job_iy, bus.job_ix,
                         bus.job_kern_addr, bus.job_out_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Dense layer
    set_cfg(0, 3, 1, 0, 5, 5, 1, 2, 3, 3, 'h100, 'h2000);
    push_layer();
    pulse_start();
    run_to_done("dense", 18);
    check("dense_job9", job9, {16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 32'h109, 32'h2009});

    // Padding and stride
    set_cfg(0, 3, 2, 1, 4, 4, 1, 1, 2, 2, 'h100, 'h3000);
    push_layer();
    pulse_start();
    run_to_done("pad", 4);

    // Bad geometry, then a good run clears the exception
    set_cfg(0, 3, 1, 0, 5, 5, 1, 2, 4, 3, 'h100, 'h2000);
    pulse_start();
    rcnt = 0;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (running) rcnt++;
      @(negedge clk);
    end
    #2;
    check("bad_run_cycles", rcnt, 1);
    check("bad_exc", exception, 1);
    check("bad_jobs", run_acc, 0);
    set_cfg(0, 3, 1, 0, 5, 5, 1, 2, 3, 3, 'h100, 'h2000);
    push_layer();
    pulse_start();
    #2;
    check("good_exc_clr", {running, exception}, 2'b10);
    run_to_done("good", 18);

    // Backpressure with completions withheld
    set_cfg(0, 3, 1, 0, 5, 5, 1, 2, 3, 3, 'h100, 'h4000);
    push_layer();
    hold_done = 1'b1;
    pulse_start();
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk); #2;
      if (run_acc >= 2) hit = 1'b1;
    end
    if (!hit) check("bp_wait_timeout", 0, 1);
    stall_left = 5;
    @(negedge clk); #2;
    snap = {bus.job_valid, bus.job_co, bus.job_oy, bus.job_ox, bus.job_iy, bus.job_ix,
            bus.job_kern_addr, bus.job_out_addr};
    check("bp_valid_stall", bus.job_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      check("bp_stable", {bus.job_valid, bus.job_co, bus.job_oy, bus.job_ox, bus.job_iy,
                          bus.job_ix, bus.job_kern_addr, bus.job_out_addr}, snap);
    end
    hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge clk); #2;
      if (!bus.job_valid) hit = 1'b1;
    end
    if (!hit) check("bp_drop_timeout", 0, 1);
    check("bp_outst4", run_acc, 4);
    @(negedge clk); #2;
    check("bp_valid_held", bus.job_valid, 0);
    force_done = 1'b1;
    void'(due_q.pop_front());
    @(negedge clk); #2;
    check("bp_valid_before", bus.job_valid, 0);
    @(negedge clk); #2;
    check("bp_valid_resume", bus.job_valid, 1);
    hold_done = 1'b0;
    run_to_done("bp", 18);

    // Spurious completion while issuing with nothing outstanding
    ready_en = 1'b0;
    set_cfg(0, 3, 1, 0, 5, 5, 1, 2, 3, 3, 'h100, 'h2000);
    pulse_start();
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge clk); #2;
      if (bus.job_valid) hit = 1'b1;
    end
    if (!hit) check("perr_valid_timeout", 0, 1);
    force_done = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #2;
    check("perr_status", {running, compute_done, exception}, 3'b001);
    check("perr_valid", bus.job_valid, 0);
    check("perr_jobs", run_acc, 0);
    ready_en = 1'b1;

    // Asynchronous reset in the middle of issuing
    set_cfg(0, 3, 1, 0, 5, 5, 1, 2, 3, 3, 'h100, 'h5000);
    push_layer();
    pulse_start();
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk); #2;
      if (run_acc >= 5) hit = 1'b1;
    end
    if (!hit) check("arst_wait_timeout", 0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_status", {running, compute_done, exception, bus.job_valid}, 4'b0000);
    check("arst_fields", {bus.job_co, bus.job_oy, bus.job_ox, bus.job_iy, bus.job_ix,
                          bus.job_kern_addr, bus.job_out_addr}, 0);
    exp_q.delete();
    due_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    due_q.delete();
    set_cfg(0, 3, 1, 0, 5, 5, 1, 2, 3, 3, 'h100, 'h2000);
    push_layer();
    pulse_start();
    run_to_done("rerun", 18);
    check("rerun_job9", job9, {16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 32'h109, 32'h2009});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    check("watchdog", 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/conv_job_ctrl.md
Name: conv_job_ctrl

Overview:
- Control stage directly downstream of axi_csr.
- Latches the layer configuration when axi_csr pulses start, validates it, and walks the output tensor (co outer, oy, ox inner), issuing one job per output pixel to the compute engine over a valid/ready handshake.
- Tracks outstanding jobs and reports running / compute_done / exception back to axi_csr's status inputs.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32): width of config words and addresses.
- MAX_OUTSTANDING, 4: maximum jobs issued but not yet completed.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch request from axi_csr; sampled on its own, no ready
- conv_mode  in  1  0 = dense conv, 1 = depthwise
- kernel_size, stride, padding  in  8 each  layer geometry
- kernel_baseaddr, output_baseaddr  in  DATA_WIDTH  base addresses
- feature_width, feature_height, feature_chin, feature_chout, output_width, output_height  in  DATA_WIDTH  layer dimensions
- running  out  1  busy status to axi_csr
- compute_done  out  1  completion status to axi_csr
- exception  out  1  error status to axi_csr
- job_valid  out  1  job offered
- job_ready  in  1  engine accepts the job
- job_co, job_oy, job_ox  out  16 each  output coordinates
- job_iy, job_ix  out  16  signed window origin: oy*stride-padding and ox*stride-padding
- job_kern_addr  out  DATA_WIDTH  kernel_baseaddr + co*KSTRIDE
- job_out_addr  out  DATA_WIDTH  output_baseaddr + linear job index
- job_done  in  1  one-cycle completion pulse from the engine

Behaviour:
- Reset: all outputs 0; state IDLE; counters and the outstanding count cleared.
- States: IDLE, CHECK, ISSUE, DRAIN, DONE, ERR.
- IDLE:
  - start=1 latches every config input in the same edge.
  - Clears compute_done and exception.
  - Moves to CHECK on the next edge.
- start outside IDLE/DONE/ERR is ignored. In DONE or ERR it acts exactly as in IDLE.
- CHECK (1 cycle): running=1. Let PW=feature_width+2*padding and PH=feature_height+2*padding. Go to ERR if any of:
  - kernel_size==0 or stride==0;
  - any of feature/output width, height, chout is 0, or feature_chin is 0;
  - kernel_size>PW or kernel_size>PH;
  - NOT((output_width-1)*stride+kernel_size <= PW < output_width*stride+kernel_size), or the same test for height.
  - Otherwise go to ISSUE. All arithmetic uses DATA_WIDTH+8 bit unsigned intermediates, so no wrap.
- KSTRIDE = kernel_size^2*feature_chin when conv_mode=0, kernel_size^2 when conv_mode=1. Computed in CHECK and registered.
- ISSUE:
  - job_valid=1 whenever outstanding<MAX_OUTSTANDING. Job fields are registered and stay stable while job_valid && !job_ready.
  - On acceptance (job_valid && job_ready), advance ox; wrap ox to 0 and increment oy; wrap oy to 0 and increment co.
  - job_out_addr increments by 1 per accepted job.
  - Address and coordinate updates are incremental only: ix += stride, job_kern_addr += KSTRIDE on a co step. No multipliers after CHECK.
  - Acceptance of the last job (co=chout-1, oy=oh-1, ox=ow-1) deasserts job_valid on the next cycle and moves to DRAIN.
- Outstanding counter:
  - +1 on acceptance, -1 on job_done; both in the same cycle leaves it unchanged.
  - job_done while outstanding==0 forces ERR.
- DRAIN: running=1. When outstanding==0, go to DONE.
- DONE: running=0 and compute_done=1, held until the next start.
- ERR:
  - running=0 and exception=1, held until the next start.
  - job_valid=0; no further jobs are issued, even if the error arose mid-ISSUE.
- Asynchronous reset at any point returns to the reset state immediately; in-flight jobs are abandoned.

Test Plan:
- Dense layer: fw=fh=5, k=3, s=1, p=0, ow=oh=3, chin=1, chout=2, kbase=0x100, obase=0x2000, job_ready=1, job_done 2 cycles after each acceptance.
  - Exactly 18 jobs; job_out_addr 0x2000..0x2011 in order.
  - Job 9 is (co=1, oy=0, ox=0) with job_kern_addr=0x109.
  - compute_done=1 after the last job_done; running 1→0 in the same edge.
- Padding/stride: fw=fh=4, k=3, s=2, p=1, ow=oh=2, chout=1.
  - Four jobs with (iy,ix)=(-1,-1),(-1,1),(1,-1),(1,1).
  - No exception.
- Bad geometry: same as the dense layer but ow=4.
  - running high for exactly 1 cycle (CHECK), then exception=1 with zero jobs issued.
  - A following good start clears exception and the run completes.
- Backpressure: job_ready low 5 cycles mid-run and job_done withheld.
  - job_valid and job fields stay stable while stalled.
  - job_valid drops once 4 jobs are outstanding and resumes one cycle after a job_done.
- Protocol error: job_done pulse while idle-in-run with 0 outstanding → exception=1 and job_valid=0.
- Reset: rst_n low during ISSUE → all outputs 0 asynchronously; the next start runs the full dense layer correctly.
